adder_20bit_serial: RTL
=======================

# adder_20bit_serial

Multi-cycle 20-bit adder that feeds one `adder_5bit` slice (ports `S`, `C`, `A`, `B`, `C0`) with successive 5-bit operand slices and collects its sum and carry outputs. It sits directly upstream and downstream of `adder_5bit`:
- upstream, it selects and drives the operand slices and the carry-in;
- downstream, it registers the slice sum and the carry-out for the next slice.

It trades latency for area: one 5-bit adder serves a 20-bit operation over four cycles, with a start/busy/done handshake toward the controller.

## Interface
Parameters:
- none. Width is fixed at 20 bits (4 slices of 5 bits).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  20  operand A; captured when start is accepted.
- `b`  in  20  operand B; captured when start is accepted.
- `cin`  in  1  carry-in of the 20-bit add; captured when start is accepted.
- `sum`  out  20  result register.
- `cout`  out  1  carry-out of the 20-bit add.
- `busy`  out  1  high in ADD and DONE states.
- `done`  out  1  one-cycle completion pulse.

## Operation
Internal registers:
- `opa`/`opb` (20 bits): operand copies.
- `carry` (1 bit): carry between slices.
- `idx` (2 bits): current slice index.
- `state`: one of IDLE, ADD, DONE.

Datapath:
- One `adder_5bit` instance.
- A = `opa[5*idx+4 : 5*idx]`, B = `opb[5*idx+4 : 5*idx]`, C0 = `carry`.

State transitions:
- IDLE, start=1 (accept):
  - load `opa` ← `a`, `opb` ← `b`, `carry` ← `cin`;
  - `idx` ← 0, `sum` ← 0, `cout` ← 0;
  - go to ADD.
- IDLE, start=0: hold all state.
- ADD:
  - each edge writes `sum[5*idx+4 : 5*idx]` ← S and `carry` ← C, then `idx` ← `idx`+1;
  - on the edge processing `idx`=3: `cout` ← C, go to DONE.
- DONE: `done`=1 for that cycle; next edge goes to IDLE.

Handshake and boundary rules:
- `start` is ignored in ADD and DONE. There is no queueing, and operands that change mid-operation have no effect.
- Slices are processed LSB-first (slice 0 = bits 4:0). The carry ripples through `carry` between cycles; there is no combinational path across slices.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^21.
- `sum` and `cout` hold the last result from DONE until the next accepted start clears them. During ADD, `sum` shows partial slices and is not valid.
- Reset at any time, including mid-ADD:
  - state → IDLE immediately;
  - `sum`=0, `cout`=0, `busy`=0, `done`=0;
  - `opa`, `opb`, `carry`, `idx` all → 0.
  - The in-flight operation is discarded, and no `done` is produced for it.
- Reset released with `start`=1: acceptance happens on the first rising edge after deassertion.

## Timing
- Reset values: `sum`=0, `cout`=0, `busy`=0, `done`=0; state IDLE.
- Let edge E0 be the edge that accepts start.
  - Edges E1–E4 process slices 0–3.
  - `done` and `busy` are high for the cycle following E4.
  - State is IDLE after E5.
- Latency: `done` asserts 4 cycles after acceptance, and the result is valid in the same cycle as `done`.
- `busy` is high from after E0 through E5, i.e. 5 cycles.
- Throughput: with `start` held high, accepts occur every 6 cycles (E0, E6, E12, ...).
- `done` is exactly one cycle wide and never asserts without a preceding accept.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- `a`=0x12345, `b`=0x00001, `cin`=0, pulse `start` → `done` 4 cycles after accept, `sum`=0x12346, `cout`=0.
- `a`=0xFFFFF, `b`=0x00001, `cin`=0 (carry ripples through all 4 slices) → `sum`=0x00000, `cout`=1. Also check after E1 that the partial `sum[4:0]`=0 and `carry`=1.
- `a`=0xFFFFF, `b`=0xFFFFF, `cin`=1 → `sum`=0xFFFFF, `cout`=1.
  - Then run `a`=0x10000, `b`=0x00010, `cin`=0 → `sum`=0x10010, `cout`=0.
  - This confirms `cout` clears on the new accept.
- Start 0x00001+0x00001; at E2 drive new operands 0xAAAAA/0x55555 with `start`=1 → they are ignored.
  - The first result is `sum`=0x00002.
  - With `start` still high, the second accept occurs at E6 and yields `sum`=0xFFFFF.
- Assert `rst` asynchronously between E2 and E3 → outputs go to 0 immediately with no clock edge, and no `done` follows.
  - After release, 0x0000F+0x00011 yields `sum`=0x00020, `cout`=0 with normal latency.
- Hold `start`=1 continuously with `a`=0x00005, `b`=0x00003 → `done` pulses every 6 cycles, each with `sum`=0x00008 and `busy` low for exactly one cycle between operations.

Source files
------------

// File: rtl/adder_20bit_serial_if.sv
// Controller-side bundle for the serial 20-bit adder: request operands in,
// result and start/busy/done handshake out.
interface adder_20bit_serial_if;
    logic        start;
    logic [19:0] a;
    logic [19:0] b;
    logic        cin;
    logic [19:0] sum;
    logic        cout;
    logic        busy;
    logic        done;

    modport master (output start, a, b, cin, input sum, cout, busy, done);
    modport slave  (input start, a, b, cin, output sum, cout, busy, done);
endinterface

// File: rtl/adder_20bit_serial.sv
// 20-bit adder built from one 5-bit slice reused over four cycles, LSB slice
// first, with the inter-slice carry held in a register.
module adder_5bit (
    output logic [4:0] S,
    output logic       C,
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       C0
);
    assign {C, S} = {1'b0, A} + {1'b0, B} + {5'b0, C0};
endmodule

module adder_20bit_serial (
    input  logic                        clk,
    input  logic                        rst,
    adder_20bit_serial_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state;
    logic [19:0] opa, opb, sum_q;
    logic        carry, cout_q, busy_q, done_q;
    logic [1:0]  idx;
    logic [4:0]  base;
    logic [4:0]  s_slice;
    logic        c_slice;

    assign base = 5'(idx) * 5'd5;

    adder_5bit u_slice (
        .S  (s_slice),
        .C  (c_slice),
        .A  (opa[base +: 5]),
        .B  (opb[base +: 5]),
        .C0 (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    sum_q[base +: 5] <= s_slice;
                    carry            <= c_slice;
                    idx              <= idx + 2'd1;
                    // Last slice: its carry-out is the carry-out of the whole add.
                    if (idx == 2'd3) begin
                        cout_q <= c_slice;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
